// File: rtl/cmov_pipe_unit_if.sv
// Handshake and register-write bus of the conditional-move pipeline.
// The master side issues instructions and collects writes; the slave side is the unit.
interface cmov_pipe_unit_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        opcode;
    logic [WIDTH-1:0]  rs_data;
    logic [WIDTH-1:0]  rt_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_valid;
    logic              out_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              illegal;

    modport master (
        output in_valid, opcode, rs_data, rt_data, rd_addr, out_ready,
        input  in_ready, out_valid, wr_en, wr_addr, wr_data, illegal
    );

    modport slave (
        input  in_valid, opcode, rs_data, rt_data, rd_addr, out_ready,
        output in_ready, out_valid, wr_en, wr_addr, wr_data, illegal
    );
endinterface

// File: rtl/cmov_pipe_unit.sv
// Two-stage MOVE/CMOV unit: S1 evaluates the move condition, S2 presents the register write.
// Optional move statistics counters are built when CMOV_STATS_EN is defined.
module cmov_pipe_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    cmov_pipe_unit_if.slave  bus
`ifdef CMOV_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] skip_cnt
`endif
);

    localparam logic [5:0] OP_MOVE    = 6'b110000;
    localparam logic [5:0] OP_CMOVLT  = 6'b110001;
    localparam logic [5:0] OP_CMOVLTU = 6'b110010;
    localparam logic [5:0] OP_CMOVEQ  = 6'b110011;
    localparam logic [5:0] OP_CMOVNE  = 6'b110100;
    localparam logic [5:0] OP_CMOVGE  = 6'b110101;

    if (WIDTH < 1 || ADDR_W < 1 || CNT_W < 1) begin : g_param_check
        $error("cmov_pipe_unit: WIDTH, ADDR_W and CNT_W must be positive");
    end

    logic              s1_valid;
    logic              s1_cond;
    logic              s1_illegal;
    logic [WIDTH-1:0]  s1_data;
    logic [ADDR_W-1:0] s1_addr;

    logic              s2_valid;
    logic              s2_cond;
    logic              s2_illegal;
    logic [WIDTH-1:0]  s2_data;
    logic [ADDR_W-1:0] s2_addr;

    logic dec_cond;
    logic dec_illegal;
    logic s1_adv;
    logic s2_adv;
    logic accept;

    // Ready depends only on the valid bits and out_ready, never on in_valid.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign accept       = bus.in_valid && s1_adv;

    always_comb begin
        dec_cond    = 1'b0;
        dec_illegal = 1'b0;
        case (bus.opcode)
            OP_MOVE:    dec_cond = 1'b1;
            OP_CMOVLT:  dec_cond = $signed(bus.rs_data) < $signed(bus.rt_data);
            OP_CMOVLTU: dec_cond = bus.rs_data < bus.rt_data;
            OP_CMOVEQ:  dec_cond = bus.rs_data == bus.rt_data;
            OP_CMOVNE:  dec_cond = bus.rs_data != bus.rt_data;
            OP_CMOVGE:  dec_cond = $signed(bus.rs_data) >= $signed(bus.rt_data);
            default:    dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_cond    <= 1'b0;
            s1_illegal <= 1'b0;
            s1_data    <= '0;
            s1_addr    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_cond    <= dec_cond;
                s1_illegal <= dec_illegal;
                s1_data    <= bus.rs_data;
                s1_addr    <= bus.rd_addr;
            end
        end
    end

    // S2 holds its contents untouched while the writeback stage stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_cond    <= 1'b0;
            s2_illegal <= 1'b0;
            s2_data    <= '0;
            s2_addr    <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_cond    <= s1_cond;
                s2_illegal <= s1_illegal;
                s2_data    <= s1_data;
                s2_addr    <= s1_addr;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.wr_en     = s2_valid && s2_cond && !s2_illegal;
    assign bus.illegal   = s2_valid && s2_illegal;
    assign bus.wr_addr   = s2_addr;
    assign bus.wr_data   = s2_data;

`ifdef CMOV_STATS_EN
    logic out_fire;

    // A handshake coinciding with a flush is squashed, so it is not counted.
    assign out_fire = s2_valid && bus.out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
            skip_cnt  <= '0;
        end else begin
            if (out_fire && s2_cond && !s2_illegal && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
            if (out_fire && !s2_cond && !s2_illegal && (skip_cnt != '1)) begin
                skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmov_pipe_unit.sv
// Directed bench for cmov_pipe_unit: conditions, latency, stall, flush, illegal, reset and stats.
module tb_cmov_pipe_unit;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
`ifdef CMOV_STATS_EN
    localparam int CNT_W  = 4;
`else
    localparam int CNT_W  = 16;
`endif

    localparam logic [5:0] OP_MOVE    = 6'b110000;
    localparam logic [5:0] OP_CMOVLT  = 6'b110001;
    localparam logic [5:0] OP_CMOVLTU = 6'b110010;
    localparam logic [5:0] OP_CMOVEQ  = 6'b110011;
    localparam logic [5:0] OP_CMOVNE  = 6'b110100;
    localparam logic [5:0] OP_CMOVGE  = 6'b110101;
    localparam logic [5:0] OP_BAD     = 6'b000101;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;

`ifdef CMOV_STATS_EN
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] skip_cnt;
`endif

    cmov_pipe_unit_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    cmov_pipe_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus)
`ifdef CMOV_STATS_EN
        ,
        .taken_cnt (taken_cnt),
        .skip_cnt  (skip_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [5:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] rd);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        bus.rd_addr  = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [31:0] tbl_rs  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                  32'h0000_1234, 32'h0000_1234};
    logic [31:0] tbl_rt  [10] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1,
                                  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_1234, 32'h0000_1234};
    logic [5:0]  tbl_op  [10] = '{OP_MOVE, OP_CMOVLT, OP_CMOVLTU, OP_CMOVEQ, OP_CMOVNE,
                                  OP_CMOVGE, OP_CMOVLT, OP_CMOVLTU, OP_CMOVEQ, OP_CMOVGE};
    logic        tbl_exp [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_wr_en",     bus.wr_en,     1'b0);
        checkOutput("rst_illegal",   bus.illegal,   1'b0);
        checkOutput("rst_in_ready",  bus.in_ready,  1'b1);
        checkOutput("rst_wr_addr",   bus.wr_addr,   5'd0);
        checkOutput("rst_wr_data",   bus.wr_data,   32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", bus.in_ready, 1'b1);

        // Each condition, including signed/unsigned and equality boundaries
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, tbl_op[i], tbl_rs[i], tbl_rt[i], 5'(i + 1));
            @(negedge clk);
            checkOutput($sformatf("cond%0d_latency", i), bus.out_valid, 1'b0);
            applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
            @(negedge clk);
            checkOutput($sformatf("cond%0d_out_valid", i), bus.out_valid, 1'b1);
            checkOutput($sformatf("cond%0d_wr_en", i),     bus.wr_en,     tbl_exp[i]);
            checkOutput($sformatf("cond%0d_wr_data", i),   bus.wr_data,   tbl_rs[i]);
            checkOutput($sformatf("cond%0d_wr_addr", i),   bus.wr_addr,   5'(i + 1));
            checkOutput($sformatf("cond%0d_illegal", i),   bus.illegal,   1'b0);
        end
        @(negedge clk);
        checkOutput("cond_drained", bus.out_valid, 1'b0);

        // Back-to-back with a three-cycle writeback stall
        applyStimulus(1'b1, OP_CMOVLT, 32'hFFFF_FFFF, 32'h1, 5'd1);
        @(negedge clk);
        applyStimulus(1'b1, OP_CMOVLT, 32'hFFFF_FFFF, 32'h1, 5'd2);
        @(negedge clk);
        checkOutput("b2b_rd1_valid", bus.out_valid, 1'b1);
        checkOutput("b2b_rd1_addr",  bus.wr_addr,   5'd1);
        applyStimulus(1'b1, OP_CMOVLT, 32'hFFFF_FFFF, 32'h1, 5'd3);
        @(negedge clk);
        checkOutput("b2b_rd2_addr", bus.wr_addr, 5'd2);
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, OP_CMOVLT, 32'hFFFF_FFFF, 32'h1, 5'd4);
        #1;
        checkOutput("b2b_full_in_ready", bus.in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d_valid", k),    bus.out_valid, 1'b1);
            checkOutput($sformatf("stall%0d_addr", k),     bus.wr_addr,   5'd2);
            checkOutput($sformatf("stall%0d_data", k),     bus.wr_data,   32'hFFFF_FFFF);
            checkOutput($sformatf("stall%0d_wr_en", k),    bus.wr_en,     1'b1);
            checkOutput($sformatf("stall%0d_in_ready", k), bus.in_ready,  1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("b2b_resume_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
        checkOutput("b2b_rd3_valid", bus.out_valid, 1'b1);
        checkOutput("b2b_rd3_addr",  bus.wr_addr,   5'd3);
        @(negedge clk);
        checkOutput("b2b_rd4_valid", bus.out_valid, 1'b1);
        checkOutput("b2b_rd4_addr",  bus.wr_addr,   5'd4);
        @(negedge clk);
        checkOutput("b2b_drained", bus.out_valid, 1'b0);

        // Flush with two entries in flight plus a concurrent input
        applyStimulus(1'b1, OP_MOVE, 32'hA5A5_0005, 32'h0, 5'd5);
        @(negedge clk);
        applyStimulus(1'b1, OP_MOVE, 32'hA5A5_0006, 32'h0, 5'd6);
        @(negedge clk);
        applyStimulus(1'b1, OP_MOVE, 32'hA5A5_0007, 32'h0, 5'd7);
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
        checkOutput("flush_out_valid", bus.out_valid, 1'b0);
        checkOutput("flush_wr_en",     bus.wr_en,     1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("flush_quiet%0d", k), bus.out_valid, 1'b0);
        end
        applyStimulus(1'b1, OP_MOVE, 32'hCAFE_0009, 32'h0, 5'd9);
        @(negedge clk);
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        checkOutput("post_flush_valid", bus.out_valid, 1'b1);
        checkOutput("post_flush_wr_en", bus.wr_en,     1'b1);
        checkOutput("post_flush_addr",  bus.wr_addr,   5'd9);
        checkOutput("post_flush_data",  bus.wr_data,   32'hCAFE_0009);
        @(negedge clk);

        // Illegal opcode
        applyStimulus(1'b1, OP_BAD, 32'h1111_1111, 32'h1111_1111, 5'd12);
        @(negedge clk);
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        checkOutput("illegal_valid", bus.out_valid, 1'b1);
        checkOutput("illegal_flag",  bus.illegal,   1'b1);
        checkOutput("illegal_wr_en", bus.wr_en,     1'b0);
        @(negedge clk);
        checkOutput("illegal_cleared", bus.illegal, 1'b0);

        // Asynchronous reset with two entries in flight
        applyStimulus(1'b1, OP_MOVE, 32'h0000_000A, 32'h0, 5'd10);
        @(negedge clk);
        applyStimulus(1'b1, OP_MOVE, 32'h0000_000B, 32'h0, 5'd11);
        @(negedge clk);
        checkOutput("pre_reset_valid", bus.out_valid, 1'b1);
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid",    bus.out_valid, 1'b0);
        checkOutput("async_rst_wr_en",    bus.wr_en,     1'b0);
        checkOutput("async_rst_in_ready", bus.in_ready,  1'b1);
        checkOutput("async_rst_wr_addr",  bus.wr_addr,   5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("post_rst_quiet%0d", k), bus.out_valid, 1'b0);
            checkOutput($sformatf("post_rst_ready%0d", k), bus.in_ready,  1'b1);
        end

`ifdef CMOV_STATS_EN
        // Statistics counters: saturation, skips, illegal ignored
        rst_n = 1'b0;
        #1;
        checkOutput("stats_rst_taken", taken_cnt, 4'h0);
        checkOutput("stats_rst_skip",  skip_cnt,  4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, OP_MOVE, 32'h5, 32'h0, 5'd1);
            @(negedge clk);
        end
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("stats_taken_sat", taken_cnt, 4'hF);
        checkOutput("stats_skip_zero", skip_cnt,  4'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_CMOVEQ, 32'h1, 32'h2, 5'd2);
            @(negedge clk);
        end
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("stats_skip3",      skip_cnt,  4'h3);
        checkOutput("stats_taken_hold", taken_cnt, 4'hF);
        applyStimulus(1'b1, OP_BAD, 32'h1, 32'h1, 5'd3);
        @(negedge clk);
        applyStimulus(1'b0, OP_MOVE, 32'h0, 32'h0, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("stats_illegal_skip",  skip_cnt,  4'h3);
        checkOutput("stats_illegal_taken", taken_cnt, 4'hF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmov_pipe_unit.md
Name: cmov_pipe_unit

Overview:
- Pipelined, parametrised conditional-move unit for the multi-cycle / pipelined Mini RISC datapath.
- Accepts one MOVE/CMOV-family instruction per cycle over a valid/ready handshake.
- Evaluates one of six move conditions on rs/rt in stage 1. Produces the register-file write (data, address, enable) in stage 2.
- Supports full backpressure and a synchronous flush for branch/exception squash.

Parameters:
- WIDTH, 32, data width of rs/rt/rd operands.
- ADDR_W, 5, register address width.
- CNT_W, 16, width of statistics counters (used only with CMOV_STATS_EN).

Ports:
- clk  input  1  system clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all in-flight entries.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  unit can accept this cycle.
- opcode  input  6  instruction opcode.
- rs_data  input  WIDTH  source operand (moved value, compare lhs).
- rt_data  input  WIDTH  compare rhs.
- rd_addr  input  ADDR_W  destination register.
- out_valid  output  1  stage-2 result valid.
- out_ready  input  1  downstream (writeback) accepts.
- wr_en  output  1  register write required (condition true).
- wr_addr  output  ADDR_W  destination register.
- wr_data  output  WIDTH  value to write (= captured rs_data).
- illegal  output  1  opcode not in the MOVE/CMOV family.
- taken_cnt  output  CNT_W  moves performed (CMOV_STATS_EN only).
- skip_cnt  output  CNT_W  moves suppressed (CMOV_STATS_EN only).

Behaviour:
- Opcode decode and condition:
  - 6'b110000 MOVE: always true.
  - 6'b110001 CMOVLT: signed rs<rt.
  - 6'b110010 CMOVLTU: unsigned rs<rt.
  - 6'b110011 CMOVEQ: rs==rt.
  - 6'b110100 CMOVNE: rs!=rt.
  - 6'b110101 CMOVGE: signed rs>=rt.
  - Any other opcode: illegal=1, condition false.
- Pipeline has two stages, each with a valid bit: S1 and S2.
  - S1 registers rs_data, rd_addr, cond, illegal.
  - S2 registers wr_data, wr_addr, wr_en, illegal.
- Transfers:
  - Accept when in_valid && in_ready.
  - Output handshake completes when out_valid && out_ready.
- Ready rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. It is purely combinational from out_ready and the valid bits; no combinational path from in_valid.
- Latency: accepted at edge N gives out_valid=1 after edge N+1. That is 2 edges, so throughput is 1/cycle with out_ready held high.
- Stall: with out_ready=0, S2 holds all outputs stable. S1 fills, then in_ready=0. No entry is lost or duplicated.
- Output gating:
  - wr_en = s2_cond && s2_valid.
  - wr_en is never 1 when out_valid=0.
  - illegal forces wr_en=0.
- Flush: at the next edge, s1_valid=0 and s2_valid=0.
  - An input presented in the same cycle is discarded, even if in_ready=1.
  - Flush has priority over every other event.
- Reset, asynchronous, rst_n=0:
  - s1_valid=s2_valid=0.
  - out_valid=0, wr_en=0, illegal=0.
  - wr_addr=0, wr_data=0.
  - Counters cleared to 0.
  - in_ready=1 while in reset and after release.
  - Reset mid-stall drops all entries.
- Width rules:
  - Signed compares use two's complement over the full WIDTH.
  - At WIDTH=32: 32'h8000_0000 < 32'h7FFF_FFFF signed, but not unsigned.

Optional Feature:
- Macro: CMOV_STATS_EN.
- Defined:
  - taken_cnt increments on each output handshake with wr_en=1.
  - skip_cnt increments on each output handshake with wr_en=0 and illegal=0.
  - Both saturate at all-ones and never wrap.
  - Flushed entries are not counted.
  - Both reset to 0.
- Undefined: taken_cnt/skip_cnt ports and counter logic are absent. No other behaviour changes.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with 2 entries in flight -> out_valid=0 and wr_en=0 immediately (asynchronously); in_ready=1; after release, nothing spurious emerges.
- Per-condition: WIDTH=32, rs=32'hFFFF_FFFF, rt=32'h0000_0001, out_ready=1 -> wr_en is:
  - MOVE 1
  - CMOVLT 1
  - CMOVLTU 0
  - CMOVEQ 0
  - CMOVNE 1
  - CMOVGE 0
  - In every case wr_data=32'hFFFF_FFFF, output 2 edges after accept.
- Back-to-back with stall: issue 4 CMOVLT (rd=1..4); drop out_ready for 3 cycles after the first output -> in_ready=0 once S1 is full; all 4 results appear in order rd=1,2,3,4; outputs stable while stalled.
- Flush: with 2 entries in flight and in_valid=1, pulse flush for 1 cycle -> next cycle out_valid=0; no outputs from the squashed entries or the concurrent input; a later MOVE completes normally.
- Illegal opcode 6'b000101 -> out_valid=1, illegal=1, wr_en=0.
- CMOV_STATS_EN, CNT_W=4: 15 MOVEs then 2 more -> taken_cnt saturates at 4'hF. 3 false CMOVEQ -> skip_cnt=3. 1 illegal -> neither counter changes.
